// File: rtl/alu_exec_unit_pkg.sv
// Shared opcode constants, FSM state encoding and decode helpers for the
// execute-stage ALU.
package alu_exec_unit_pkg;

  localparam logic [4:0] ALU_NOP = 5'd0;
  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_AND = 5'd3;
  localparam logic [4:0] ALU_OR  = 5'd4;
  localparam logic [4:0] ALU_XOR = 5'd5;
  localparam logic [4:0] ALU_SLL = 5'd6;
  localparam logic [4:0] ALU_SRL = 5'd7;
  localparam logic [4:0] ALU_BEQ = 5'd8;
  localparam logic [4:0] ALU_BNE = 5'd9;
  localparam logic [4:0] ALU_BLT = 5'd10;
  localparam logic [4:0] ALU_BGE = 5'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [4:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_exec_unit_simple_ops.sv
// Purely combinational single-cycle ALU (arithmetic, logic, branch compare).
// Shifts and undefined codes produce zero here; the exec unit sequences shifts.
module alu_simple_ops
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result,
  output logic            o_bcond
);

  // Decode the opcode into a result word or a branch condition.
  always_comb begin
    o_result = {XLEN{1'b0}};
    o_bcond  = 1'b0;
    case (i_op)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_BEQ: o_bcond  = (i_a == i_b);
      ALU_BNE: o_bcond  = (i_a != i_b);
      ALU_BLT: o_bcond  = ($signed(i_a) < $signed(i_b));
      ALU_BGE: o_bcond  = ($signed(i_a) >= $signed(i_b));
      default: begin
        o_result = {XLEN{1'b0}};
        o_bcond  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops through alu_simple_ops, SLL/SRL iterated
// one bit per cycle, valid/ready on both sides and a synchronous flush.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_alu_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_bcond,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  state_t          r_state;
  logic [XLEN-1:0] r_shreg;
  logic [XLEN-1:0] r_result;
  logic [SHW-1:0]  r_cnt;
  logic            r_left;
  logic            r_bcond;
  logic [4:0]      r_rd_hold;
  logic [4:0]      r_out_rd;

  logic            w_accept;
  logic            w_is_shift;
  logic            w_start_shift;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_simple_result;
  logic            w_simple_bcond;
  logic [XLEN-1:0] w_load_result;
  logic            w_load_bcond;
  logic [XLEN-1:0] w_shift_next;

  alu_simple_ops #(.XLEN(XLEN)) u_simple_ops (
    .i_op     (in_alu_op),
    .i_a      (in_a),
    .i_b      (in_b),
    .o_result (w_simple_result),
    .o_bcond  (w_simple_bcond)
  );

  assign in_ready      = !flush && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
  assign w_accept      = in_valid && in_ready;
  assign w_shamt       = in_b[SHW-1:0];
  assign w_is_shift    = is_shift_op(in_alu_op);
  assign w_start_shift = w_is_shift && (w_shamt != {SHW{1'b0}});

  // A shift by zero completes like any single-cycle op, passing operand A.
  assign w_load_result = w_is_shift ? in_a : w_simple_result;
  assign w_load_bcond  = w_is_shift ? 1'b0 : w_simple_bcond;
  assign w_shift_next  = r_left ? {r_shreg[XLEN-2:0], 1'b0} : {1'b0, r_shreg[XLEN-1:1]};

  assign out_valid  = (r_state == ST_DONE);
  assign busy       = (r_state == ST_SHIFT);
  assign out_result = r_result;
  assign out_bcond  = r_bcond;
  assign out_rd     = r_out_rd;

  // Handshake FSM, shift sequencing and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_shreg   <= {XLEN{1'b0}};
      r_result  <= {XLEN{1'b0}};
      r_cnt     <= {SHW{1'b0}};
      r_left    <= 1'b0;
      r_bcond   <= 1'b0;
      r_rd_hold <= 5'd0;
      r_out_rd  <= 5'd0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= {SHW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            if (w_start_shift) begin
              r_shreg   <= in_a;
              r_cnt     <= w_shamt;
              r_left    <= (in_alu_op == ALU_SLL);
              r_rd_hold <= in_rd;
              r_state   <= ST_SHIFT;
            end else begin
              r_result <= w_load_result;
              r_bcond  <= w_load_bcond;
              r_out_rd <= in_rd;
              r_state  <= ST_DONE;
            end
          end else if ((r_state == ST_DONE) && out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // The final one-bit step lands straight in the result register.
          if (r_cnt == CNT_ONE) begin
            r_result <= w_shift_next;
            r_bcond  <= 1'b0;
            r_out_rd <= r_rd_hold;
            r_cnt    <= {SHW{1'b0}};
            r_state  <= ST_DONE;
          end else begin
            r_shreg <= w_shift_next;
            r_cnt   <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute stage. Consumes the 5-bit alu_op produced by the ALU control unit, plus two XLEN-bit operands from the ID/EX path. Produces a registered result and a branch condition.
- Single-cycle ops complete in one cycle. SLL/SRL run iteratively at 1 bit per cycle to keep the datapath small.
- Uses a valid/ready handshake on both sides so later labs can stall or flush it.

Parameters:
- XLEN, 32, operand/result width; shift amount taken from in_b[$clog2(XLEN)-1:0]

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous abort of any in-flight or held operation
- in_valid  input  1  operands and alu_op valid
- in_ready  output  1  unit accepts this cycle
- in_alu_op  input  5  ALU_* code from alu_opcodes.v
- in_a  input  XLEN  operand A (rs1)
- in_b  input  XLEN  operand B (rs2 or immediate)
- in_rd  input  5  destination tag, passed through untouched
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts this cycle
- out_result  output  XLEN  ALU result
- out_bcond  output  1  branch taken (branch ops only)
- out_rd  output  5  tag of the completed op
- busy  output  1  high in SHIFT state

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (reset_n). Asserting it at any time forces IDLE, out_valid=0, out_result=0, out_bcond=0, out_rd=0, busy=0 and clears internal counters.
- States: IDLE, SHIFT, DONE.
- in_ready = !flush && (state==IDLE || (state==DONE && out_ready)). A transfer occurs at a rising edge when in_valid && in_ready.
- Accepting a non-shift op, or a shift with shamt==0: compute combinationally, register the result, go to DONE. out_valid rises the cycle after acceptance (latency 1).
- Accepting SLL/SRL with shamt N>0: latch a, N, op and rd; go to SHIFT. Each SHIFT cycle shifts by 1 (SRL is logical, zero fill) and decrements N. When N reaches 0, go to DONE. out_valid rises N+1 cycles after acceptance.
- DONE: outputs are held stable while out_ready=0.
  - out_ready=1 and new transfer: next edge loads the new op (back-to-back, no bubble).
  - out_ready=1 and no transfer: go to IDLE with out_valid=0.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - AND/OR/XOR are bitwise.
  - BEQ/BNE compare for equality.
  - BLT/BGE are signed.
  - Branch ops give out_result=0 and out_bcond=compare outcome.
  - All non-branch ops give out_bcond=0.
  - ALU_NOP and any undefined code give result=0, bcond=0, and still complete with latency 1.
- flush: at the next edge go to IDLE, drop any op, out_valid=0. Flush overrides a simultaneous acceptance and an in-progress shift.
- Shift amount uses only the low $clog2(XLEN) bits of in_b. Upper bits are ignored.

Decomposition:
- ALU_* opcode constants stay in the shared alu_opcodes.v header. Add state encodings (ST_IDLE/ST_SHIFT/ST_DONE) there or in a local header.
- One combinational sub-module, alu_simple_ops (op, a, b -> result, bcond), handles all single-cycle ops. It is reusable by a future single-cycle ALU.
- Shift sequencing and handshake stay in alu_exec_unit.

Test Plan:
- ADD a=0x7FFFFFFF, b=1, out_ready=1 -> out_valid one cycle later, result 0x80000000, bcond 0. SUB 0-1 -> 0xFFFFFFFF.
- SLL a=1, b=0x00000025 (shamt 5) -> busy for 5 cycles, out_valid 6 cycles after accept, result 0x20. SRL a=0x80000000, b=31 -> 0x1. SLL shamt 0 -> latency 1, result = a.
- BLT a=0xFFFFFFFF, b=1 -> bcond 1, result 0. BGE same operands -> bcond 0. BEQ 5,5 -> 1. BNE 5,5 -> 0.
- Back-pressure: hold out_ready=0 for 3 cycles after an XOR completes -> outputs and out_rd stable, in_ready=0. Release with in_valid for an AND -> AND result next cycle, no bubble.
- flush asserted in the 2nd cycle of SLL shamt 10 -> IDLE next cycle, out_valid never rises. flush together with in_valid -> in_ready=0, op not accepted.
- reset_n pulsed low asynchronously mid-SHIFT -> all outputs 0 immediately. After release, the next ADD 2+3 -> 5 with latency 1.
